// File: rtl/scale_fifo_reader_if.sv
// Bus bundle for scale_fifo_reader.
// Carries the FIFO read port and the outgoing valid/ready pixel stream.
//   master : the reader. Drives fifo_rd_en and the m_* stream, and
//            receives FIFO data/flags and m_ready.
//   slave  : the environment (FIFO plus downstream stage).
interface scale_fifo_reader_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_rd_empty;
  logic                  fifo_almost_empty;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_sof;
  logic                  m_eol;
  logic                  m_eof;

  modport master (
    output fifo_rd_en, m_valid, m_data, m_sof, m_eol, m_eof,
    input  fifo_rd_data, fifo_rd_empty, fifo_almost_empty, m_ready
  );

  modport slave (
    input  fifo_rd_en, m_valid, m_data, m_sof, m_eol, m_eof,
    output fifo_rd_data, fifo_rd_empty, fifo_almost_empty, m_ready
  );
endinterface

// File: rtl/scale_fifo_reader.sv
// Read-side consumer of the scaler async FIFO (rd_clk domain only).
// Pulls pixels from the FIFO (1-cycle read latency), stages them in a
// 2-entry skid buffer and presents them as a valid/ready stream with
// start-of-frame / end-of-line / end-of-frame markers.
// Ports:
//   rd_clk, rd_rst_n  clock, async active-low reset
//   frame_start       pulse, arms one frame when idle
//   frame_abort       pulse, abandons the current frame
//   bus (master)      FIFO read port + m_* output stream
//   busy              high while a frame is running
//   frame_done        1-cycle pulse after the last pixel is accepted
//   starve_cnt        saturating count of starvation cycles
module scale_fifo_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int H_ACTIVE   = 1280,
  parameter int V_ACTIVE   = 720,
  parameter int CNT_W      = 12
) (
  input  logic        rd_clk,
  input  logic        rd_rst_n,
  input  logic        frame_start,
  input  logic        frame_abort,
  scale_fifo_reader_if.master bus,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] starve_cnt
);

  localparam int TOTAL = H_ACTIVE * V_ACTIVE;
  localparam int ISS_W = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state, state_nx;
  logic [1:0]            occ;
  logic                  pend;
  logic [DATA_WIDTH-1:0] sb_head, sb_tail;
  logic [CNT_W-1:0]      pix_cnt, line_cnt;
  logic [ISS_W-1:0]      issued;

  logic       run, pop, wr, rd_en, all_issued, last_pix, last_line, valid;
  logic [2:0] level;
  logic       unused_ok;

  // Almost-empty is a status flag only; it plays no part in issue.
  assign unused_ok = &{1'b0, bus.fifo_almost_empty};

  assign run        = (state == RUN);
  assign valid      = (occ != 2'd0);
  assign pop        = valid & bus.m_ready;
  assign all_issued = (issued == ISS_W'(TOTAL));
  assign last_pix   = (pix_cnt == CNT_W'(H_ACTIVE - 1));
  assign last_line  = (line_cnt == CNT_W'(V_ACTIVE - 1));

  // Entries the buffer will hold after this edge, counting the read in
  // flight. pop implies occ>=1, so this never underflows.
  assign level = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};
  assign rd_en = run & ~bus.fifo_rd_empty & (level <= 3'd1) & ~all_issued;

  // Data of an in-flight read is dropped once the frame is abandoned.
  assign wr = pend & run & ~frame_abort;

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = valid;
  assign bus.m_data     = sb_head;
  assign bus.m_sof      = valid & (pix_cnt == '0) & (line_cnt == '0);
  assign bus.m_eol      = valid & last_pix;
  assign bus.m_eof      = valid & last_pix & last_line;

  assign busy       = run;
  assign frame_done = (state == DONE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (frame_start) state_nx = RUN;
      RUN: begin
        if (frame_abort)                          state_nx = IDLE;
        else if (pop & last_pix & last_line)      state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) state <= IDLE;
    else           state <= state_nx;
  end

  // Read pipeline and skid buffer (head = oldest entry).
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      pend    <= 1'b0;
      occ     <= 2'd0;
      sb_head <= '0;
      sb_tail <= '0;
    end else begin
      pend <= rd_en;
      if (run & frame_abort) begin
        occ <= 2'd0;
      end else begin
        case ({wr, pop})
          2'b10: begin
            if (occ == 2'd0) sb_head <= bus.fifo_rd_data;
            else             sb_tail <= bus.fifo_rd_data;
            occ <= occ + 2'd1;
          end
          2'b01: begin
            sb_head <= sb_tail;
            occ     <= occ - 2'd1;
          end
          2'b11: begin
            if (occ == 2'd1) begin
              sb_head <= bus.fifo_rd_data;
            end else begin
              sb_head <= sb_tail;
              sb_tail <= bus.fifo_rd_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Position of the head pixel and count of reads issued this frame.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      pix_cnt  <= '0;
      line_cnt <= '0;
      issued   <= '0;
    end else if (state == IDLE) begin
      pix_cnt  <= '0;
      line_cnt <= '0;
      issued   <= '0;
    end else if (run) begin
      issued <= issued + {{(ISS_W-1){1'b0}}, rd_en};
      if (pop) begin
        if (last_pix) begin
          pix_cnt  <= '0;
          line_cnt <= last_line ? '0 : line_cnt + CNT_W'(1);
        end else begin
          pix_cnt <= pix_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Starvation: downstream is ready, nothing to give it, and the frame
  // still owes pixels. Only reset clears the count.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n)
      starve_cnt <= '0;
    else if (run & ~valid & bus.m_ready & ~all_issued & (starve_cnt != 16'hFFFF))
      starve_cnt <= starve_cnt + 16'd1;
  end

endmodule
